// File: rtl/mem_req_arbiter_if.sv
// mem_arb_if: bundles every handshake/bus signal around mem_req_arbiter.
//
// Requester side (one lane per requester):
//   req_valid/req_is_write/req_addr/req_wdata   request from user logic
//   req_grant                                   request accepted this cycle
//   resp_valid/resp_data                        read response routed to owner
//   resp_grant                                  owner consumes its response
// DRAM side:
//   mem_req_valid/is_write/addr/wdata, mem_req_grant   selected request
//   mem_resp_valid/mem_resp_data, mem_resp_grant       returning read data
//
// Modports: slave = the arbiter, master = user logic plus DRAM model.
interface mem_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_is_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_grant;

  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] resp_data;
  logic [NUM_REQ-1:0]             resp_grant;

  logic                           mem_req_valid;
  logic                           mem_req_is_write;
  logic [ADDR_W-1:0]              mem_req_addr;
  logic [DATA_W-1:0]              mem_req_wdata;
  logic                           mem_req_grant;

  logic                           mem_resp_valid;
  logic [DATA_W-1:0]              mem_resp_data;
  logic                           mem_resp_grant;

  modport slave (
    input  req_valid, req_is_write, req_addr, req_wdata, resp_grant,
    input  mem_req_grant, mem_resp_valid, mem_resp_data,
    output req_grant, resp_valid, resp_data,
    output mem_req_valid, mem_req_is_write, mem_req_addr, mem_req_wdata,
    output mem_resp_grant
  );

  modport master (
    output req_valid, req_is_write, req_addr, req_wdata, resp_grant,
    output mem_req_grant, mem_resp_valid, mem_resp_data,
    input  req_grant, resp_valid, resp_data,
    input  mem_req_valid, mem_req_is_write, mem_req_addr, mem_req_wdata,
    input  mem_resp_grant
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one DRAM request/response channel among NUM_REQ
// requesters. Work-conserving round-robin selection; read responses are
// routed back to their issuer in issue order using a tag FIFO of requester ids.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   bus            mem_arb_if.slave, requester lanes and DRAM channel
//   err_orphan_out sticky: a response arrived with no outstanding read
//   perf_stall_out cycles with a pending request but no grant
//
// Optional feature: define MEM_ARB_PERF_EN to build the stall counter;
// otherwise perf_stall_out is tied to zero.
module mem_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int LOG_TAGS = 5,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64
) (
  input  logic        clk,
  input  logic        rst,
  mem_arb_if.slave    bus,
  output logic        err_orphan_out,
  output logic [31:0] perf_stall_out
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 1 << LOG_TAGS;
  localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_tag_mem [DEPTH];
  logic [LOG_TAGS:0] r_wr_ptr;
  logic [LOG_TAGS:0] r_rd_ptr;
  logic              r_err_orphan;

  logic               w_full;
  logic               w_empty;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_any;
  logic [ID_W-1:0]    w_sel;
  logic [ID_W-1:0]    w_sel_next;
  logic [ID_W:0]      w_scan;
  logic               w_accept;
  logic               w_push;
  logic [ID_W-1:0]    w_head;
  logic               w_resp_ok;
  logic               w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[LOG_TAGS] != r_rd_ptr[LOG_TAGS]) &&
                   (r_wr_ptr[LOG_TAGS-1:0] == r_rd_ptr[LOG_TAGS-1:0]);

  // Reads need a free tag slot; the pre-pop full flag is used so a
  // same-cycle response consume never lets a read through a full FIFO.
  assign w_elig = rst ? '0 : (bus.req_valid & (bus.req_is_write | {NUM_REQ{~w_full}}));

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ); first eligible wins.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_scan = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_scan >= NREQ_W) w_scan = w_scan - NREQ_W;
      if (!w_any && w_elig[w_scan[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_scan[ID_W-1:0];
      end
    end
  end

  assign w_sel_next = (w_sel == LAST_ID) ? '0 : w_sel + ID_W'(1);

  assign bus.mem_req_valid    = w_any;
  assign bus.mem_req_is_write = bus.req_is_write[w_sel];
  assign bus.mem_req_addr     = bus.req_addr[w_sel];
  assign bus.mem_req_wdata    = bus.req_wdata[w_sel];

  assign w_accept = w_any & bus.mem_req_grant;
  assign w_push   = w_accept & ~bus.mem_req_is_write;

  always_comb begin
    bus.req_grant = '0;
    if (w_accept) bus.req_grant[w_sel] = 1'b1;
  end

  // Response path: only the owner of the oldest outstanding read sees valid.
  assign w_head    = r_tag_mem[r_rd_ptr[LOG_TAGS-1:0]];
  assign w_resp_ok = ~rst & ~w_empty & bus.mem_resp_valid;
  assign w_pop     = w_resp_ok & bus.resp_grant[w_head];

  always_comb begin
    bus.resp_valid = '0;
    if (w_resp_ok) bus.resp_valid[w_head] = 1'b1;
  end

  // Data is broadcast; only the valid bit is steered.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp_data
    assign bus.resp_data[g] = bus.mem_resp_data;
  end

  assign bus.mem_resp_grant = w_pop;
  assign err_orphan_out     = r_err_orphan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_accept) r_rr_ptr <= w_sel_next;
      if (w_push)   r_wr_ptr <= r_wr_ptr + (LOG_TAGS+1)'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + (LOG_TAGS+1)'(1);
      if (bus.mem_resp_valid && w_empty) r_err_orphan <= 1'b1;
    end
  end

  // Tag storage carries no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr[LOG_TAGS-1:0]] <= w_sel;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
    end else if ((|bus.req_valid) && !w_accept && (r_perf_stall != 32'hFFFF_FFFF)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall_out = r_perf_stall;
`else
  assign perf_stall_out = 32'h0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  logic        clk;
  logic        rst;
  logic        err_orphan;
  logic [31:0] perf_stall;

  mem_arb_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(64)) bus ();

  mem_req_arbiter #(.NUM_REQ(4), .LOG_TAGS(2), .ADDR_W(32), .DATA_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .err_orphan_out (err_orphan),
    .perf_stall_out (perf_stall)
  );

  typedef struct {
    logic [3:0] v;
    logic [3:0] w;
    logic       gi;
    int         sel;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] data;
  } sb_t;

  sb_t  sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_stall = 0;
  int   gcnt[4];
  vec_t tbl[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_perf(input string nm);
`ifdef MEM_ARB_PERF_EN
    chk(nm, 64'(perf_stall), 64'(exp_stall));
`else
    chk(nm, 64'(perf_stall), 64'h0);
`endif
  endtask

  // One cycle: drive at negedge, check combinational outputs 1ns later.
  task automatic step(input logic [3:0] v, input logic [3:0] w, input logic gi,
                      input logic rv, input logic [3:0] rg, input int sel,
                      input string nm);
    int          hid;
    logic [3:0]  exp_rv;
    logic        exp_rg;
    logic [63:0] rdata;
    logic [3:0]  exp_gr;
    @(negedge clk);
    bus.req_valid      = v;
    bus.req_is_write   = w;
    bus.mem_req_grant  = gi;
    bus.mem_resp_valid = rv;
    bus.resp_grant     = rg;
    hid    = 0;
    exp_rv = 4'b0;
    exp_rg = 1'b0;
    rdata  = 64'hDEAD_BEEF_0000_0000;
    if (rv && sb.size() > 0) begin
      hid    = sb[0].id;
      rdata  = sb[0].data;
      exp_rv = 4'b0001 << hid;
      exp_rg = rg[hid];
    end
    bus.mem_resp_data = rdata;
    exp_gr = (gi && sel >= 0) ? (4'b0001 << sel) : 4'b0000;
    #1;
    chk({nm, " mem_valid"}, 64'(bus.mem_req_valid), 64'(sel >= 0));
    if (sel >= 0) begin
      chk({nm, " mem_addr"}, 64'(bus.mem_req_addr), 64'h100 + 64'(sel));
      chk({nm, " mem_wdata"}, bus.mem_req_wdata, 64'h1000 + 64'(sel));
    end
    chk({nm, " grant"}, 64'(bus.req_grant), 64'(exp_gr));
    chk({nm, " resp_valid"}, 64'(bus.resp_valid), 64'(exp_rv));
    chk({nm, " mem_resp_grant"}, 64'(bus.mem_resp_grant), 64'(exp_rg));
    if (exp_rg) begin
      chk({nm, " resp_data"}, bus.resp_data[hid], rdata);
      void'(sb.pop_front());
    end
    if (exp_gr != 0 && !w[sel]) sb.push_back('{sel, {$urandom, $urandom}});
    if (v != 0 && exp_gr == 0) exp_stall++;
  endtask

  task automatic idle();
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, -1, "idle");
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst                = 1'b1;
      bus.req_valid      = 4'hF;
      bus.req_is_write   = 4'h0;
      bus.mem_req_grant  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.resp_grant     = 4'hF;
      #1;
      chk("rst grant", 64'(bus.req_grant), 64'h0);
      chk("rst mem_valid", 64'(bus.mem_req_valid), 64'h0);
      chk("rst resp_valid", 64'(bus.resp_valid), 64'h0);
      chk("rst mem_resp_grant", 64'(bus.mem_resp_grant), 64'h0);
    end
    @(negedge clk);
    rst                = 1'b0;
    bus.req_valid      = 4'h0;
    bus.mem_req_grant  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.resp_grant     = 4'h0;
    sb.delete();
    exp_stall = 0;
    #1;
    chk("post-rst err_orphan", 64'(err_orphan), 64'h0);
    chk_perf("post-rst perf");
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid      = '0;
    bus.req_is_write   = '0;
    bus.mem_req_grant  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.resp_grant     = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i]  = 32'h100 + 32'(i);
      bus.req_wdata[i] = 64'h1000 + 64'(i);
    end

    do_reset(4);

    // Round-robin selection with writes only; rr pointer starts at 0.
    tbl[0] = '{4'b0000, 4'hF, 1'b1, -1};
    tbl[1] = '{4'b0110, 4'hF, 1'b0,  1};
    tbl[2] = '{4'b0110, 4'hF, 1'b1,  1};
    tbl[3] = '{4'b0011, 4'hF, 1'b1,  0};
    tbl[4] = '{4'b1001, 4'hF, 1'b1,  3};
    tbl[5] = '{4'b1001, 4'hF, 1'b1,  0};
    tbl[6] = '{4'b1111, 4'hF, 1'b0,  1};
    tbl[7] = '{4'b1111, 4'hF, 1'b1,  1};
    for (int i = 0; i < 8; i++)
      step(tbl[i].v, tbl[i].w, tbl[i].gi, 1'b0, 4'h0, tbl[i].sel, $sformatf("vec%0d", i));
    chk_perf("perf after table");

    // Fairness: 100 back-to-back grants, pointer is at 2 here.
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    for (int i = 0, p = 2; i < 100; i++) begin
      step(4'hF, 4'hF, 1'b1, 1'b0, 4'h0, p, "rr");
      gcnt[p]++;
      p = (p + 1) % 4;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr count%0d", i), 64'(gcnt[i]), 64'd25);

    // Stalled winner keeps priority.
    step(4'b0001, 4'hF, 1'b1, 1'b0, 4'h0, 0, "stall pre");
    for (int i = 0; i < 5; i++) step(4'b0100, 4'hF, 1'b0, 1'b0, 4'h0, 2, "stall hold");
    step(4'b0101, 4'hF, 1'b1, 1'b0, 4'h0, 2, "stall win");
    step(4'b0001, 4'hF, 1'b1, 1'b0, 4'h0, 0, "stall next");
    chk_perf("perf after stall");

    // Single read, response 10 cycles later.
    step(4'b0001, 4'h0, 1'b1, 1'b0, 4'h0, 0, "rd0");
    for (int i = 0; i < 9; i++) idle();
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'hF, -1, "rd0 resp");

    // Tag FIFO full (depth 4).
    for (int i = 0; i < 4; i++)
      step(4'b0001 << i, 4'h0, 1'b1, 1'b0, 4'h0, i, $sformatf("fill%0d", i));
    step(4'b0011, 4'b0010, 1'b1, 1'b0, 4'h0, 1, "full write");
    step(4'b0001, 4'h0, 1'b1, 1'b0, 4'h0, -1, "full read");
    step(4'b0001, 4'h0, 1'b1, 1'b1, 4'hF, -1, "full pop nobypass");
    step(4'b0001, 4'h0, 1'b1, 1'b1, 4'hF, 0, "push+pop");
    step(4'b0100, 4'h0, 1'b1, 1'b0, 4'h0, 2, "refill");
    step(4'b1000, 4'h0, 1'b1, 1'b0, 4'h0, -1, "full again");
    for (int i = 0; i < 4; i++) step(4'h0, 4'h0, 1'b0, 1'b1, 4'hF, -1, "drain");
    chk_perf("perf after full");

    // In-order delivery with a slow owner.
    step(4'b0010, 4'h0, 1'b1, 1'b0, 4'h0, 1, "ord rd1");
    step(4'b1000, 4'h0, 1'b1, 1'b0, 4'h0, 3, "ord rd3");
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b1, 4'b1000, -1, "backpressure");
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'b1010, -1, "ord resp1");
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'b1000, -1, "ord resp3");

    // Reset with reads outstanding, then a late response is an orphan.
    step(4'b0001, 4'h0, 1'b1, 1'b0, 4'h0, 0, "orph rd0");
    step(4'b0010, 4'h0, 1'b1, 1'b0, 4'h0, 1, "orph rd1");
    do_reset(2);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'hF, -1, "orphan");
    idle();
    chk("err_orphan set", 64'(err_orphan), 64'h1);
    idle();
    chk("err_orphan sticky", 64'(err_orphan), 64'h1);
    do_reset(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
